// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: shared constants and types for the SimpleRISC fetch stage.
//   NOP_INSTR     - encoding injected into the IF/OF latch for bubbles
//   OPCODE_W      - opcode field width (top bits of the instruction word)
//   OP_NOP        - nop opcode
//   fetch_state_t - fetch FSM states
package simplerisc_pkg;

    localparam int                  OPCODE_W  = 5;
    localparam logic [OPCODE_W-1:0] OP_NOP    = 5'b01101;
    localparam logic [31:0]         NOP_INSTR = {OP_NOP, {(32-OPCODE_W){1'b0}}};

    // REQ: nothing outstanding; WAIT: one live request outstanding;
    // DISCARD: one request outstanding whose response must be dropped.
    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus.
//   imem_req   - single-cycle request pulse (fetch -> memory)
//   imem_addr  - word address, valid with imem_req
//   imem_valid - response strobe, one per request (memory -> fetch)
//   imem_rdata - instruction word, valid with imem_valid
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);

endinterface

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry instruction+pc holding buffer used when a memory
// response arrives while the IF/OF latch is stalled.
//   clk, rst_n          - clock, async active-low reset
//   load                - capture load_instr/load_pc, mark valid
//   drain               - entry consumed by the latch, mark empty
//   clear               - flush (branch redirect); wins over load/drain
//   load_instr, load_pc - data to capture
//   valid, instr, pc    - current entry
module fetch_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: SimpleRISC instruction fetch stage plus the IF/OF latch.
// Keeps the PC, issues one word request at a time, and loads the IF/OF
// latch with one instruction per cycle. Stalls park at most one response in
// a skid buffer; branch redirects flush the latch and skid and drop the stale
// in-flight response.
//   clk, rst_n   - clock, async active-low reset
//   stall        - hazard unit: hold the IF/OF latch
//   branch_taken - EX redirect (flush), priority over everything
//   branch_pc    - redirect target
//   imem         - instruction memory bus (master side)
//   if_instr     - IF/OF instruction to decoder
//   if_pc        - PC of if_instr
//   if_valid     - IF/OF holds a real instruction
module fetch_unit
    import simplerisc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_pc,
    fetch_unit_if.master        imem,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc,
    output logic                if_valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic         if_valid_q, if_valid_d;

    logic         skid_valid, skid_load, skid_drain;
    logic [31:0]  skid_instr, skid_pc;
    logic         issue, resp_live;

    fetch_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (branch_taken),
        .load_instr (imem.imem_rdata),
        .load_pc    (req_pc_q),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_comb begin
        // rst_n gating keeps the request low while reset is held; the FSM
        // sits in REQ then and would otherwise advertise a request.
        issue = rst_n && !branch_taken && !skid_valid &&
                (state_q == REQ || (state_q == WAIT && imem.imem_valid && !stall));
        // Only a response in WAIT carries a usable instruction; in DISCARD it is stale.
        resp_live = (state_q == WAIT) && imem.imem_valid;

        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;

        if (branch_taken) begin
            pc_d       = branch_pc;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            // A request still in flight must be swallowed when it returns.
            if (state_q != REQ && !imem.imem_valid) state_d = DISCARD;
            else                                    state_d = REQ;
        end else begin
            if (issue) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + 32'd4;
                state_d  = WAIT;
            end else if (imem.imem_valid && state_q != REQ) begin
                state_d = REQ;
            end

            if (!stall) begin
                if (skid_valid) begin
                    if_valid_d = 1'b1;
                    if_instr_d = skid_instr;
                    if_pc_d    = skid_pc;
                    skid_drain = 1'b1;
                end else if (resp_live) begin
                    if_valid_d = 1'b1;
                    if_instr_d = imem.imem_rdata;
                    if_pc_d    = req_pc_q;
                end else begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end
            end else if (resp_live) begin
                skid_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem.imem_req  = issue;
    assign imem.imem_addr = pc_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    assign if_valid       = if_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A memory model with a
// programmable latency answers requests with ~addr. The reference keeps the
// expected fetch address, a queue of returned-but-not-yet-delivered words and
// a flush epoch; it checks imem_req/imem_addr and the IF/OF latch every cycle.
// Literal expectations from the test plan pin the reference.
module tb_fetch_unit;
    import simplerisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_pc = '0;
    logic [31:0] if_instr, if_pc;
    logic        if_valid;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .imem         (bus),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_valid     (if_valid)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // memory model
    bit          pend = 0;
    int          cnt = 0;
    int          mem_lat = 1;
    logic [31:0] pend_addr = '0;
    int          pend_epoch = 0;
    int          epoch = 0;

    // reference
    logic [31:0] q[$];
    logic [31:0] exp_fetch = '0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_instr = NOP_INSTR;
    bit          last_req = 0;
    logic [31:0] last_addr = '0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        bus.imem_valid = 1'b0;
        pend = 0;
        q.delete();
        epoch++;
        exp_fetch = '0;
        exp_valid = 1'b0;
        exp_pc = '0;
        exp_instr = NOP_INSTR;
        #1;
        chk("reset if_valid", {31'd0, if_valid}, 32'd0);
        chk("reset if_instr", if_instr, 32'h6800_0000);
        chk("reset if_pc", if_pc, 32'd0);
        chk("reset imem_req", {31'd0, bus.imem_req}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive inputs at negedge, check request, model the edge,
    // check the latch just after the edge.
    task automatic cyc(input bit st, input bit bt, input logic [31:0] bpc);
        bit          v, exp_req, ok_resp;
        logic [31:0] a;
        @(negedge clk);
        rst_n = 1'b1;
        stall = st;
        branch_taken = bt;
        branch_pc = bpc;
        v = 0;
        if (pend) begin
            cnt--;
            if (cnt <= 0) v = 1;
        end
        bus.imem_valid = v;
        bus.imem_rdata = v ? word(pend_addr) : 32'hDEAD_BEEF;
        #1;
        // request allowed only when nothing undelivered is held, and either
        // nothing is outstanding or a live response is accepted unstalled
        exp_req = !bt && (q.size() == 0) &&
                  (!pend || (v && !st && pend_epoch == epoch));
        last_req = bus.imem_req;
        last_addr = bus.imem_addr;
        chk("imem_req", {31'd0, last_req}, {31'd0, exp_req});
        if (last_req) chk("imem_addr", last_addr, exp_fetch);
        @(posedge clk);
        ok_resp = v && (pend_epoch == epoch) && !bt;
        if (v) pend = 0;
        if (ok_resp) q.push_back(pend_addr);
        if (last_req) begin
            pend = 1;
            cnt = mem_lat;
            pend_addr = last_addr;
            pend_epoch = epoch;
            exp_fetch = exp_fetch + 32'd4;
        end
        if (bt) begin
            epoch++;
            q.delete();
            exp_fetch = bpc;
            exp_valid = 1'b0;
            exp_instr = NOP_INSTR;
        end else if (!st) begin
            if (q.size() > 0) begin
                a = q.pop_front();
                exp_valid = 1'b1;
                exp_pc = a;
                exp_instr = word(a);
            end else begin
                exp_valid = 1'b0;
                exp_instr = NOP_INSTR;
            end
        end
        #1;
        chk("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
        chk("if_instr", if_instr, exp_instr);
        if (exp_valid) chk("if_pc", if_pc, exp_pc);
    endtask

    task automatic run_until_req();
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 32'd0);
            if (last_req) return;
        end
        nvec++;
        nerr++;
        $display("FAIL timeout waiting for imem_req");
    endtask

    task automatic run_until_valid(output logic [31:0] freq, output logic [31:0] fpc);
        bit got = 0;
        freq = 32'hFFFF_FFFF;
        fpc = 32'hFFFF_FFFF;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 32'd0);
            if (last_req && !got) begin
                got = 1;
                freq = last_addr;
            end
            if (if_valid) begin
                fpc = if_pc;
                return;
            end
        end
        nvec++;
        nerr++;
        $display("FAIL timeout waiting for if_valid");
    endtask

    logic [31:0] pcs[1:12];
    logic        vals[1:12];
    logic        reqs[1:12];
    logic [31:0] fr, fp;
    logic [31:0] raddr[$];
    bit          st_pat[20] = '{0,1,0,0,1,1,0,1,0,0,0,1,1,1,0,0,1,0,1,0};

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        do_reset();

        // streaming with 1-cycle memory, then a 3-cycle stall
        mem_lat = 1;
        for (int k = 1; k <= 12; k++) begin
            cyc(k >= 7 && k <= 9, 0, 32'd0);
            pcs[k] = if_pc;
            vals[k] = if_valid;
            reqs[k] = last_req;
        end
        for (int k = 1; k <= 6; k++) chk("req every cycle", {31'd0, reqs[k]}, 32'd1);
        chk("lit pc c2", pcs[2], 32'd0);
        chk("lit pc c3", pcs[3], 32'd4);
        chk("lit pc c4", pcs[4], 32'd8);
        chk("lit pc c5", pcs[5], 32'd12);
        chk("lit valid c5", {31'd0, vals[5]}, 32'd1);
        for (int k = 7; k <= 9; k++) chk("stall hold pc", pcs[k], 32'd16);
        for (int k = 7; k <= 10; k++) chk("no req with skid", {31'd0, reqs[k]}, 32'd0);
        chk("skid out pc", pcs[10], 32'd20);
        chk("bubble after drain", {31'd0, vals[11]}, 32'd0);
        chk("resume pc", pcs[12], 32'd24);

        // redirect with a 3-cycle memory while a request is in flight
        mem_lat = 3;
        run_until_req();
        cyc(0, 1, 32'h100);
        run_until_valid(fr, fp);
        chk("redirect req addr", fr, 32'h100);
        chk("redirect first pc", fp, 32'h100);

        // branch and stall together with the skid full
        mem_lat = 1;
        run_until_req();
        cyc(1, 0, 32'd0);
        cyc(1, 1, 32'h200);
        chk("flush valid", {31'd0, if_valid}, 32'd0);
        chk("flush instr", if_instr, 32'h6800_0000);
        cyc(0, 0, 32'd0);
        chk("flush next req", {31'd0, last_req}, 32'd1);
        chk("flush next addr", last_addr, 32'h200);
        chk("skid cleared", {31'd0, if_valid}, 32'd0);
        run_until_valid(fr, fp);
        chk("flush first pc", fp, 32'h200);

        // back-to-back branches while discarding
        mem_lat = 3;
        run_until_req();
        cyc(0, 1, 32'h40);
        cyc(0, 1, 32'h80);
        run_until_valid(fr, fp);
        chk("b2b req addr", fr, 32'h80);
        chk("b2b first pc", fp, 32'h80);

        // address wrap
        mem_lat = 1;
        cyc(0, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 32'd0);
            if (last_req) raddr.push_back(last_addr);
        end
        if (raddr.size() >= 3) begin
            chk("wrap a0", raddr[0], 32'hFFFF_FFF8);
            chk("wrap a1", raddr[1], 32'hFFFF_FFFC);
            chk("wrap a2", raddr[2], 32'h0000_0000);
        end else begin
            nvec++;
            nerr++;
            $display("FAIL wrap: got %0d requests want >=3", raddr.size());
        end

        // mixed stall pattern, 2-cycle memory
        mem_lat = 2;
        foreach (st_pat[i]) cyc(st_pat[i], 0, 32'd0);

        // reset mid-operation
        do_reset();
        mem_lat = 1;
        run_until_valid(fr, fp);
        chk("post-reset req addr", fr, 32'd0);
        chk("post-reset first pc", fp, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
